// File: rtl/wb_slow_control_pkg.sv
// Shared widths, error data and FSM encoding for the slow-control Wishbone arbiter.
package wb_slow_control_pkg;
  localparam int WB_ADR_W = 16;
  localparam int WB_DAT_W = 8;
  localparam logic [WB_DAT_W-1:0] WB_ERR_DATA = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;
endpackage

// File: rtl/wb_arb_timeout.sv
// Slave-ack watchdog: counts enabled cycles and flags the last cycle before abort.
module wb_arb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk40MHz,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk40MHz) begin
    if (rst || clear)
      cnt <= '0;
    else if (enable && !expired)
      cnt <= cnt + CW'(1);
  end

  // expired marks the TIMEOUT-th BUSY cycle so the abort lands on that edge
  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = (cnt == CW'(TIMEOUT - 1));
    end
  endgenerate
endmodule

// File: rtl/wb_slow_control_arbiter.sv
// Two-master round-robin arbiter for the 8-bit/16-bit slow-control Wishbone bus.
module wb_slow_control_arbiter
  import wb_slow_control_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                clk40MHz,
  input  logic                rst,
  input  logic [WB_ADR_W-1:0] m0_adr_i,
  input  logic                m0_wen_i,
  input  logic                m0_stb_i,
  input  logic [WB_DAT_W-1:0] m0_dat_i,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  output logic [WB_DAT_W-1:0] m0_dat_o,
  input  logic [WB_ADR_W-1:0] m1_adr_i,
  input  logic                m1_wen_i,
  input  logic                m1_stb_i,
  input  logic [WB_DAT_W-1:0] m1_dat_i,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic [WB_DAT_W-1:0] m1_dat_o,
  output logic [WB_ADR_W-1:0] s_adr_o,
  output logic                s_wen_o,
  output logic                s_stb_o,
  output logic [WB_DAT_W-1:0] s_dat_o,
  input  logic                s_ack_i,
  input  logic [WB_DAT_W-1:0] s_dat_i
);
  arb_state_t state;
  logic       last;
  logic       gnt;
  logic       nxt_gnt;
  logic       expired;
  logic       to_clear;
  logic       to_enable;

  // on a tie the master not served last wins
  assign nxt_gnt   = (m0_stb_i && m1_stb_i) ? ~last : m1_stb_i;
  assign to_clear  = (state != BUSY);
  assign to_enable = (state == BUSY) && !s_ack_i;

  wb_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk40MHz (clk40MHz),
    .rst      (rst),
    .clear    (to_clear),
    .enable   (to_enable),
    .expired  (expired)
  );

  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      gnt      <= 1'b0;
      s_adr_o  <= '0;
      s_wen_o  <= 1'b0;
      s_stb_o  <= 1'b0;
      s_dat_o  <= '0;
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;
      m0_err_o <= 1'b0;
      m1_err_o <= 1'b0;
      m0_dat_o <= '0;
      m1_dat_o <= '0;
    end else begin
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;
      m0_err_o <= 1'b0;
      m1_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_stb_i || m1_stb_i) begin
            gnt     <= nxt_gnt;
            s_adr_o <= nxt_gnt ? m1_adr_i : m0_adr_i;
            s_wen_o <= nxt_gnt ? m1_wen_i : m0_wen_i;
            s_dat_o <= nxt_gnt ? m1_dat_i : m0_dat_i;
            s_stb_o <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // a real ack always beats the timeout on the same edge
          if (s_ack_i || expired) begin
            s_stb_o <= 1'b0;
            last    <= gnt;
            state   <= DONE;
            if (gnt) m1_ack_o <= 1'b1;
            else     m0_ack_o <= 1'b1;
            if (!s_ack_i) begin
              if (gnt) begin
                m1_err_o <= 1'b1;
                m1_dat_o <= WB_ERR_DATA;
              end else begin
                m0_err_o <= 1'b1;
                m0_dat_o <= WB_ERR_DATA;
              end
            end else if (!s_wen_o) begin
              if (gnt) m1_dat_o <= s_dat_i;
              else     m0_dat_o <= s_dat_i;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_slow_control_arbiter.sv
// Scenario bench for the slow-control arbiter against a transaction-level model.
`timescale 1ns/1ps
module tb_wb_slow_control_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] m0_adr, m1_adr, s_adr_o;
  logic        m0_wen, m1_wen, m0_stb, m1_stb;
  logic [7:0]  m0_dat, m1_dat, m0_dat_o, m1_dat_o, s_dat_o, s_dat;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic        s_wen_o, s_stb_o, s_ack;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // transaction-level model state
  logic       mdl_last;
  logic [7:0] mdl_dat [2];

  always #12 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_slow_control_arbiter #(.TIMEOUT(TO)) dut (
    .clk40MHz (clk),
    .rst      (rst),
    .m0_adr_i (m0_adr), .m0_wen_i (m0_wen), .m0_stb_i (m0_stb), .m0_dat_i (m0_dat),
    .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o), .m0_dat_o (m0_dat_o),
    .m1_adr_i (m1_adr), .m1_wen_i (m1_wen), .m1_stb_i (m1_stb), .m1_dat_i (m1_dat),
    .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o), .m1_dat_o (m1_dat_o),
    .s_adr_o  (s_adr_o), .s_wen_o (s_wen_o), .s_stb_o (s_stb_o), .s_dat_o (s_dat_o),
    .s_ack_i  (s_ack), .s_dat_i (s_dat)
  );

  function automatic logic [45:0] all_outs();
    return {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o,
            s_adr_o, s_wen_o, s_stb_o, s_dat_o};
  endfunction

  task automatic model_reset();
    mdl_last   = 1'b1;
    mdl_dat[0] = 8'h00;
    mdl_dat[1] = 8'h00;
  endtask

  // One arbitrated transfer, called at a negedge. ack_at is the strobe cycle
  // on which the slave acks (1-based); anything outside 1..TO never acks.
  task automatic do_txn(input logic r0, input logic r1,
                        input logic [15:0] a0, input logic [15:0] a1,
                        input logic w0, input logic w1,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input int ack_at, input logic [7:0] rd,
                        output logic obs_w, output int rise_cyc);
    int w, n, exp_len;
    logic exp_err, ew;
    logic [15:0] ea;
    logic [7:0] ed;
    w       = (r0 && r1) ? (mdl_last ? 0 : 1) : (r1 ? 1 : 0);
    ea      = w ? a1 : a0;
    ed      = w ? d1 : d0;
    ew      = w ? w1 : w0;
    exp_err = !(ack_at >= 1 && ack_at <= TO);
    exp_len = exp_err ? TO : ack_at;
    obs_w    = 1'b0;
    rise_cyc = 0;
    m0_stb = r0; m0_adr = a0; m0_wen = w0; m0_dat = d0;
    m1_stb = r1; m1_adr = a1; m1_wen = w1; m1_dat = d1;
    n = 0;
    while (!s_stb_o && n < 6) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (s_stb_o !== 1'b1) begin
      fails++;
      $display("FAIL grant_wait: s_stb_o=%b after %0d cycles, required 1", s_stb_o, n);
      m0_stb = 1'b0; m1_stb = 1'b0;
      return;
    end
    rise_cyc = cyc;
    n = 0;
    while (s_stb_o && n < 20) begin
      n++;
      tests++;
      if ({s_adr_o, s_dat_o, s_wen_o, m0_ack_o, m1_ack_o} !== {ea, ed, ew, 2'b00}) begin
        fails++;
        $display("FAIL slave_hold: adr/dat/wen/acks=%h/%h/%b/%b%b required %h/%h/%b/00",
                 s_adr_o, s_dat_o, s_wen_o, m0_ack_o, m1_ack_o, ea, ed, ew);
      end
      s_ack = (n == ack_at);
      s_dat = rd;
      @(negedge clk);
    end
    s_ack = 1'b0;
    if (exp_err)  mdl_dat[w] = 8'hFF;
    else if (!ew) mdl_dat[w] = rd;
    mdl_last = w[0];
    tests++;
    if (n !== exp_len) begin
      fails++;
      $display("FAIL strobe_len: %0d cycles, required %0d", n, exp_len);
    end
    tests++;
    if ({m1_ack_o, m0_ack_o} !== (w ? 2'b10 : 2'b01)) begin
      fails++;
      $display("FAIL ack: m1/m0 ack=%b%b, required winner m%0d", m1_ack_o, m0_ack_o, w);
    end
    tests++;
    if ({m1_err_o, m0_err_o} !== (exp_err ? (w ? 2'b10 : 2'b01) : 2'b00)) begin
      fails++;
      $display("FAIL err: m1/m0 err=%b%b, required err=%b on m%0d", m1_err_o, m0_err_o, exp_err, w);
    end
    tests++;
    if ({m0_dat_o, m1_dat_o} !== {mdl_dat[0], mdl_dat[1]}) begin
      fails++;
      $display("FAIL rdata: m0/m1 dat=%h/%h, required %h/%h", m0_dat_o, m1_dat_o, mdl_dat[0], mdl_dat[1]);
    end
    obs_w = m1_ack_o;
    if (w) m1_stb = 1'b0; else m0_stb = 1'b0;
    @(negedge clk);
    tests++;
    if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0000) begin
      fails++;
      $display("FAIL pulse_width: ack/err=%b%b%b%b one cycle later, required 0000",
               m0_ack_o, m1_ack_o, m0_err_o, m1_err_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_ack = 1'b0; s_dat = 8'h00;
    m0_stb = 1'b0; m1_stb = 1'b0; m0_adr = '0; m1_adr = '0;
    m0_wen = 1'b0; m1_wen = 1'b0; m0_dat = '0; m1_dat = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    tests++;
    if (all_outs() !== 46'd0) begin
      fails++;
      $display("FAIL reset_outputs: %h, required 0", all_outs());
    end
  endtask

  task automatic test_single_write();
    logic ow; int rc, start;
    start = cyc;
    do_txn(1, 0, 16'h0012, 16'h0, 1, 0, 8'h3C, 8'h0, 3, 8'h77, ow, rc);
    tests++;
    if (rc - start !== 1) begin
      fails++;
      $display("FAIL grant_latency: %0d cycles, required 1", rc - start);
    end
  endtask

  task automatic test_read_return();
    logic ow; int rc;
    do_txn(0, 1, 16'h0, 16'h0040, 0, 0, 8'h0, 8'h0, 2, 8'hA5, ow, rc);
    tests++;
    if ({m1_dat_o, m0_dat_o} !== 16'hA500) begin
      fails++;
      $display("FAIL read_return: m1/m0 dat=%h/%h, required a5/00", m1_dat_o, m0_dat_o);
    end
  endtask

  task automatic test_fairness();
    logic ow; int rc, prev;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      do_txn(1, 1, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 1, 0, 8'(i), 8'h0, 2, 8'h10 + 8'(i), ow, rc);
      tests++;
      if (ow !== 1'(i % 2)) begin
        fails++;
        $display("FAIL fairness_order: txn %0d granted m%0d, required m%0d", i, ow, i % 2);
      end
      if (i > 0) begin
        tests++;
        if (rc - prev !== 4) begin
          fails++;
          $display("FAIL b2b_spacing: %0d cycles between strobes, required 4", rc - prev);
        end
      end
      prev = rc;
    end
    m0_stb = 1'b0; m1_stb = 1'b0;
  endtask

  task automatic test_timeout();
    logic ow; int rc;
    do_txn(1, 0, 16'hBEEF, 16'h0, 0, 0, 8'h0, 8'h0, 0, 8'h00, ow, rc);
    tests++;
    if (m0_dat_o !== 8'hFF) begin
      fails++;
      $display("FAIL timeout_data: m0_dat_o=%h, required ff", m0_dat_o);
    end
    do_txn(0, 1, 16'h0, 16'h0101, 0, 1, 8'h0, 8'h42, 1, 8'h00, ow, rc);
    tests++;
    if (ow !== 1'b1) begin
      fails++;
      $display("FAIL after_timeout_grant: granted m%0d, required m1", ow);
    end
  endtask

  task automatic test_ack_on_timeout();
    logic ow; int rc;
    do_txn(1, 0, 16'h0055, 16'h0, 0, 0, 8'h0, 8'h0, TO, 8'h5A, ow, rc);
    tests++;
    if (m0_dat_o !== 8'h5A) begin
      fails++;
      $display("FAIL ack_on_timeout: m0_dat_o=%h, required 5a", m0_dat_o);
    end
  endtask

  task automatic test_random();
    logic ow; int rc, sel;
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(1, 3);
      do_txn(sel[0], sel[1], 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             8'($urandom), 8'($urandom), $urandom_range(0, TO + 1), 8'($urandom), ow, rc);
    end
    m0_stb = 1'b0; m1_stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_busy();
    logic ow; int rc;
    do_txn(1, 0, 16'h0A0A, 16'h0, 1, 0, 8'h11, 8'h0, 1, 8'h00, ow, rc);
    m0_stb = 1'b1; m0_adr = 16'h0B0B; m0_wen = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (s_stb_o !== 1'b1) begin
      fails++;
      $display("FAIL rst_setup: s_stb_o=%b on 2nd strobe cycle, required 1", s_stb_o);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (all_outs() !== 46'd0) begin
      fails++;
      $display("FAIL rst_mid_busy: outputs=%h, required 0", all_outs());
    end
    m0_stb = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    do_txn(1, 1, 16'h0C0C, 16'h0D0D, 1, 1, 8'h22, 8'h33, 1, 8'h00, ow, rc);
    tests++;
    if (ow !== 1'b0) begin
      fails++;
      $display("FAIL rst_tie_break: granted m%0d, required m0", ow);
    end
    m1_stb = 1'b0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_return();
    test_fairness();
    test_timeout();
    test_ack_on_timeout();
    test_random();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
